// File: rtl/f1_issue_fifo_pkg.sv
// rtl/f1_issue_fifo_pkg.sv - shared F1 opcode encodings and entry packing helpers
package f1_issue_fifo_pkg;

  localparam logic [1:0] F1_UNIT_ABS    = 2'b00;
  localparam logic [1:0] F1_UNIT_MINMAX = 2'b01;
  localparam logic [1:0] F1_UNIT_ADDSUB = 2'b10;
  localparam logic [1:0] F1_UNIT_RSVD   = 2'b11;

  localparam int F1_F_W = 4;

  // Entry layout is {f, op2, op1, op0} with f in the MSBs.
  function automatic int f1_entry_w(input int width);
    return F1_F_W + 3 * width;
  endfunction

endpackage

// File: rtl/f1_entry_ram.sv
// rtl/f1_entry_ram.sv - DEPTH x W register array, synchronous write, asynchronous read
module f1_entry_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 100,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are intentionally not reset; validity is tracked by the FIFO occupancy.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/f1_issue_fifo.sv
// rtl/f1_issue_fifo.sv - issue FIFO feeding the F1 ALU, filters and counts reserved opcodes
module f1_issue_fifo
  import f1_issue_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_f,
  input  logic [WIDTH-1:0]       in_op0,
  input  logic [WIDTH-1:0]       in_op1,
  input  logic [WIDTH-1:0]       in_op2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_f,
  output logic [WIDTH-1:0]       out_op0,
  output logic [WIDTH-1:0]       out_op1,
  output logic [WIDTH-1:0]       out_op2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_pulse,
  output logic [CNTW-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = f1_entry_w(WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  logic          accept;
  logic          rsvd;
  logic          push;
  logic          drop;
  logic          pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);

  // A reserved op still completes the handshake; it is just never written.
  assign accept = in_valid & in_ready;
  assign rsvd   = (in_f[1:0] == F1_UNIT_RSVD);
  assign push   = accept & ~rsvd;
  assign drop   = accept & rsvd;
  assign pop    = out_valid & out_ready;

  assign wdata = {in_f, in_op2, in_op1, in_op0};
  assign {out_f, out_op2, out_op1, out_op0} = rdata;

  f1_entry_ram #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count      <= count + CW'(push) - CW'(pop);
      drop_pulse <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_f1_issue_fifo.sv
// tb/tb_f1_issue_fifo.sv - scoreboard bench for f1_issue_fifo
module tb_f1_issue_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int EW    = 4 + 3 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_f = '0;
  logic [WIDTH-1:0] in_op0 = '0, in_op1 = '0, in_op2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_f;
  logic [WIDTH-1:0] out_op0, out_op1, out_op2;
  logic [2:0]       count;
  logic             drop_pulse;
  logic [15:0]      drop_cnt;

  logic             s_in_valid = 1'b0;
  logic             s_in_ready;
  logic [3:0]       s_in_f = 4'h3;
  logic             s_out_valid;
  logic [3:0]       s_out_f;
  logic [WIDTH-1:0] s_out_op0, s_out_op1, s_out_op2;
  logic [2:0]       s_count;
  logic             s_drop_pulse;
  logic [1:0]       s_drop_cnt;

  int passed = 0;
  int total  = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  f1_issue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
    .in_op0(in_op0), .in_op1(in_op1), .in_op2(in_op2), .out_valid(out_valid),
    .out_ready(out_ready), .out_f(out_f), .out_op0(out_op0), .out_op1(out_op1),
    .out_op2(out_op2), .count(count), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  f1_issue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_f(s_in_f),
    .in_op0(32'd0), .in_op1(32'd0), .in_op2(32'd0), .out_valid(s_out_valid),
    .out_ready(1'b0), .out_f(s_out_f), .out_op0(s_out_op0), .out_op1(s_out_op1),
    .out_op2(s_out_op2), .count(s_count), .drop_pulse(s_drop_pulse), .drop_cnt(s_drop_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input int a, input int b, input int c);
    in_valid = v;
    in_f     = f;
    in_op0   = WIDTH'(a);
    in_op1   = WIDTH'(b);
    in_op2   = WIDTH'(c);
  endtask

  // Monitor: compare the head at each pop, then record newly accepted non-reserved ops.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pop", {out_f, out_op2, out_op1, out_op0}, 128'hx);
        else check("pop_order", {out_f, out_op2, out_op1, out_op0}, exp_q.pop_front());
      end
      if (in_valid && in_ready && in_f[1:0] != 2'b11)
        exp_q.push_back({in_f, in_op2, in_op1, in_op0});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_count", count, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_drop_cnt", drop_cnt, 0);

    // single push, held under stall
    drive(1, 4'h2, 5, 3, 0);
    tick();
    drive(0, 4'h0, 0, 0, 0);
    check("t2_out_valid", out_valid, 1);
    check("t2_out_f", out_f, 2);
    check("t2_out_op0", out_op0, 5);
    check("t2_out_op1", out_op1, 3);
    check("t2_alu_sum", out_op0 + out_op1, 8);
    tick();
    tick();
    check("t2_held_op0", out_op0, 5);
    check("t2_held_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_drained", count, 0);

    // fill to full, refuse the fifth, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1, 4'h2, i, 0, 0);
      tick();
    end
    check("t3_full_count", count, 4);
    check("t3_full_in_ready", in_ready, 0);
    drive(1, 4'h2, 5, 0, 0);
    out_ready = 1'b1;
    check("t3_full_with_out_ready", in_ready, 0);
    out_ready = 1'b0;
    tick();
    drive(0, 4'h0, 0, 0, 0);
    check("t3_fifth_refused", count, 4);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("t3_empty_count", count, 0);
    check("t3_empty_queue", exp_q.size(), 0);

    // simultaneous push/pop at count=2 across pointer wrap
    drive(1, 4'h6, 10, 1, 2);
    tick();
    drive(1, 4'h1, 11, 3, 4);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive(1, 4'hA, 20 + k, k, 32'hFFFF_FFFF - k);
      tick();
      check("t4_count_steady", count, 2);
    end
    drive(0, 4'h0, 0, 0, 0);
    repeat (2) tick();
    out_ready = 1'b0;
    check("t4_drained", count, 0);

    // reserved ops are consumed and counted, never queued
    drive(1, 4'h3, 1, 1, 1);
    tick();
    check("t5_pulse_a", drop_pulse, 1);
    check("t5_out_valid_a", out_valid, 0);
    drive(1, 4'hB, 2, 2, 2);
    tick();
    drive(0, 4'h0, 0, 0, 0);
    check("t5_pulse_b", drop_pulse, 1);
    check("t5_drop_cnt", drop_cnt, 2);
    tick();
    check("t5_pulse_low", drop_pulse, 0);
    check("t5_count", count, 0);
    s_in_valid = 1'b1;
    repeat (5) tick();
    s_in_valid = 1'b0;
    check("t5_sat_cnt", s_drop_cnt, 3);

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'h0, 40 + i, 0, 0);
      tick();
    end
    drive(0, 4'h0, 0, 0, 0);
    check("t6_pre_count", count, 3);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("t6_rst_count", count, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_drop_cnt", drop_cnt, 0);
    drive(1, 4'h2, 77, 0, 0);
    tick();
    drive(0, 4'h0, 0, 0, 0);
    check("t6_post_valid", out_valid, 1);
    check("t6_post_op0", out_op0, 77);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_final_count", count, 0);
    check("t6_final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
